// File: rtl/sbox_sched.sv
// rtl/sbox_sched.sv - issue scheduler and randomness stager for the masked S-box bank
// Optional feature: SBOX_SCHED_RR_EN selects round-robin arbitration (fixed priority otherwise).
module sbox_sched #(
   parameter int d      = 2,
   parameter int NLANES = 4,
   parameter int RND_W  = NLANES*18*d*(d-1)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req0_valid,
   output logic                           req0_ready,
   input  logic [8*NLANES*d-1:0]          req0_data,
   input  logic                           req1_valid,
   output logic                           req1_ready,
   input  logic [8*NLANES*d-1:0]          req1_data,
   input  logic                           rnd_valid,
   output logic                           rnd_ready,
   input  logic [RND_W-1:0]               rnd_data,
   output logic [8*NLANES*d-1:0]          sb_in,
   output logic [NLANES*4*d*(d-1)-1:0]    sb_rnd0,
   output logic [NLANES*2*d*(d-1)-1:0]    sb_rnd1,
   output logic [NLANES*4*d*(d-1)-1:0]    sb_rnd2,
   output logic [NLANES*8*d*(d-1)-1:0]    sb_rnd3,
   input  logic [8*NLANES*d-1:0]          sb_out,
   output logic                           resp_valid,
   output logic                           resp_id,
   output logic [8*NLANES*d-1:0]          resp_data,
   output logic                           busy
);
   localparam int DW  = 8*NLANES*d;
   localparam int S0W = NLANES*4*d*(d-1);
   localparam int S1W = NLANES*2*d*(d-1);
   localparam int S2W = NLANES*4*d*(d-1);
   localparam int S3W = NLANES*8*d*(d-1);
   localparam int O1  = S0W;
   localparam int O2  = S0W + S1W;
   localparam int O3  = S0W + S1W + S2W;

   logic           w_req_ok;
   logic           w_gnt;
   logic           w_issue;
   logic [4:1]     r_v;
   logic [4:1]     r_id;
   logic [S1W-1:0] r_d1;
   logic [S2W-1:0] r_d2a, r_d2b;
   logic [S3W-1:0] r_d3a, r_d3b, r_d3c;

   assign w_req_ok = rnd_valid & (req0_valid | req1_valid);

`ifdef SBOX_SCHED_RR_EN
   logic r_last;

   always_comb begin
      w_gnt = ~req0_valid;
      if (req0_valid && req1_valid) w_gnt = ~r_last;
   end

   // Reset value 1 lets requester 0 win the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 1'b1;
      end else if (w_req_ok) begin
         r_last <= w_gnt;
      end
   end
`else
   always_comb begin
      w_gnt = ~req0_valid;
   end
`endif

   // Grant outputs are forced low while reset is held.
   assign w_issue    = rst_n & w_req_ok;
   assign req0_ready = w_issue & ~w_gnt;
   assign req1_ready = w_issue & w_gnt;
   assign rnd_ready  = w_issue;
   assign sb_in      = w_issue ? (w_gnt ? req1_data : req0_data) : {DW{1'b0}};
   assign sb_rnd0    = w_issue ? rnd_data[0 +: S0W] : {S0W{1'b0}};

   // Idle cycles load zeros so no slice survives past its own operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v   <= '0;
         r_id  <= '0;
         r_d1  <= '0;
         r_d2a <= '0;
         r_d2b <= '0;
         r_d3a <= '0;
         r_d3b <= '0;
         r_d3c <= '0;
      end else begin
         r_v   <= {r_v[3:1], w_req_ok};
         r_id  <= {r_id[3:1], w_req_ok & w_gnt};
         r_d1  <= w_req_ok ? rnd_data[O1 +: S1W] : {S1W{1'b0}};
         r_d2a <= w_req_ok ? rnd_data[O2 +: S2W] : {S2W{1'b0}};
         r_d2b <= r_d2a;
         r_d3a <= w_req_ok ? rnd_data[O3 +: S3W] : {S3W{1'b0}};
         r_d3b <= r_d3a;
         r_d3c <= r_d3b;
      end
   end

   assign sb_rnd1    = r_v[1] ? r_d1  : {S1W{1'b0}};
   assign sb_rnd2    = r_v[2] ? r_d2b : {S2W{1'b0}};
   assign sb_rnd3    = r_v[3] ? r_d3c : {S3W{1'b0}};
   assign resp_valid = r_v[4];
   assign resp_id    = r_id[4];
   assign resp_data  = rst_n ? sb_out : {DW{1'b0}};
   assign busy       = |r_v;
endmodule

// File: tb/tb_sbox_sched.sv
// tb/tb_sbox_sched.sv - self-checking bench for sbox_sched with a behavioural S-box bank
module tb_sbox_sched;
   localparam int D   = 2;
   localparam int NL  = 4;
   localparam int RW  = NL*18*D*(D-1);
   localparam int DW  = 8*NL*D;
   localparam int S0W = NL*4*D*(D-1);
   localparam int S1W = NL*2*D*(D-1);
   localparam int S2W = NL*4*D*(D-1);
   localparam int S3W = NL*8*D*(D-1);
   localparam int O1  = S0W;
   localparam int O2  = S0W + S1W;
   localparam int O3  = S0W + S1W + S2W;

   logic           clk, rst_n;
   logic           req0_valid, req0_ready, req1_valid, req1_ready, rnd_valid, rnd_ready;
   logic [DW-1:0]  req0_data, req1_data, sb_in, sb_out, resp_data;
   logic [RW-1:0]  rnd_data;
   logic [S0W-1:0] sb_rnd0;
   logic [S1W-1:0] sb_rnd1;
   logic [S2W-1:0] sb_rnd2;
   logic [S3W-1:0] sb_rnd3;
   logic           resp_valid, resp_id, busy;

   sbox_sched #(.d(D), .NLANES(NL), .RND_W(RW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
      .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
      .sb_in(sb_in), .sb_rnd0(sb_rnd0), .sb_rnd1(sb_rnd1), .sb_rnd2(sb_rnd2), .sb_rnd3(sb_rnd3),
      .sb_out(sb_out), .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] aes_sbox(input logic [7:0] x);
      logic [7:0] inv, s, t;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      s = inv; t = inv;
      for (int k = 0; k < 4; k++) begin
         t = {t[6:0], t[7]};
         s ^= t;
      end
      return s ^ 8'h63;
   endfunction

   function automatic logic [8*NL-1:0] sbox_word(input logic [8*NL-1:0] w);
      logic [8*NL-1:0] r;
      for (int l = 0; l < NL; l++) r[l*8 +: 8] = aes_sbox(w[l*8 +: 8]);
      return r;
   endfunction

   function automatic logic [DW-1:0] mask_w(input logic [8*NL-1:0] bytes, input logic [DW-1:0] m);
      logic [DW-1:0] w;
      for (int l = 0; l < NL; l++)
         for (int b = 0; b < 8; b++) begin
            w[l*8*D + b*D]     = m[l*8*D + b*D];
            w[l*8*D + b*D + 1] = bytes[l*8 + b] ^ m[l*8*D + b*D];
         end
      return w;
   endfunction

   function automatic logic [8*NL-1:0] unmask_w(input logic [DW-1:0] w);
      logic [8*NL-1:0] r;
      for (int l = 0; l < NL; l++)
         for (int b = 0; b < 8; b++) r[l*8 + b] = w[l*8*D + b*D] ^ w[l*8*D + b*D + 1];
      return r;
   endfunction

   function automatic logic [DW-1:0] rdw();
      return {$urandom(), $urandom()};
   endfunction

   function automatic logic [RW-1:0] rrnd();
      logic [159:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[RW-1:0];
   endfunction

   // Behavioural 4-stage S-box bank: unmask, substitute, remask with fresh shares.
   logic [DW-1:0] p1, p2, p3, p4;
   always @(posedge clk) begin
      p1 <= mask_w(sbox_word(unmask_w(sb_in)), {$urandom(), $urandom()});
      p2 <= p1;
      p3 <= p2;
      p4 <= p3;
   end
   assign sb_out = p4;

   // Reference model: events are booked into future cycle slots at issue time.
   bit              e_rv [8];
   bit              e_id [8];
   logic [8*NL-1:0] e_dat [8];
   logic [63:0]     e_r1 [8], e_r2 [8], e_r3 [8];
   bit              m_last = 1'b1;
   bit              o_r0, o_r1, o_rr;

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         e_rv[i] = 1'b0; e_id[i] = 1'b0; e_dat[i] = '0;
         e_r1[i] = '0; e_r2[i] = '0; e_r3[i] = '0;
      end
      m_last = 1'b1;
   endtask

   task automatic step(input bit v0, input bit v1, input bit rv, input bit rst,
                       input logic [DW-1:0] dd0, input logic [DW-1:0] dd1, input logic [RW-1:0] rr);
      int  s;
      bit  iss, g, eb;
      req0_valid = v0; req1_valid = v1; rnd_valid = rv;
      req0_data = dd0; req1_data = dd1; rnd_data = rr; rst_n = rst;
      #4;
      s = cyc % 8;
      if (!rst) model_clear();
      iss = rst && rv && (v0 || v1);
`ifdef SBOX_SCHED_RR_EN
      g = (v0 && v1) ? !m_last : !v0;
`else
      g = !v0;
`endif
      eb = e_rv[s] | e_rv[(cyc+1)%8] | e_rv[(cyc+2)%8] | e_rv[(cyc+3)%8];
      o_r0 = req0_ready; o_r1 = req1_ready; o_rr = rnd_ready;
      chk("req0_ready", 64'(req0_ready), 64'(iss && !g));
      chk("req1_ready", 64'(req1_ready), 64'(iss && g));
      chk("rnd_ready", 64'(rnd_ready), 64'(iss));
      chk("sb_in", sb_in, iss ? (g ? dd1 : dd0) : 64'h0);
      chk("sb_rnd0", 64'(sb_rnd0), iss ? 64'(rr[0 +: S0W]) : 64'h0);
      chk("sb_rnd1", 64'(sb_rnd1), e_r1[s]);
      chk("sb_rnd2", 64'(sb_rnd2), e_r2[s]);
      chk("sb_rnd3", 64'(sb_rnd3), e_r3[s]);
      chk("resp_valid", 64'(resp_valid), 64'(e_rv[s]));
      chk("busy", 64'(busy), 64'(eb));
      if (e_rv[s]) begin
         chk("resp_id", 64'(resp_id), 64'(e_id[s]));
         chk("resp_data_unmasked", 64'(unmask_w(resp_data)), 64'(e_dat[s]));
      end
      e_rv[s] = 1'b0; e_r1[s] = '0; e_r2[s] = '0; e_r3[s] = '0;
      if (iss) begin
         e_r1[(cyc+1)%8] = 64'(rr[O1 +: S1W]);
         e_r2[(cyc+2)%8] = 64'(rr[O2 +: S2W]);
         e_r3[(cyc+3)%8] = 64'(rr[O3 +: S3W]);
         e_rv[(cyc+4)%8] = 1'b1;
         e_id[(cyc+4)%8] = g;
         e_dat[(cyc+4)%8] = sbox_word(unmask_w(g ? dd1 : dd0));
         m_last = g;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b1, rdw(), rdw(), rrnd());
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   typedef struct {
      bit       v0, v1, rv;
      bit [2:0] e_rr;
      bit [2:0] e_fp;
   } vec_t;

   vec_t        tbl [8];
   bit   [2:0]  ev;
   bit          gseq [4];
   logic [63:0] exp_w;

   initial begin
      req0_valid = 1'b0; req1_valid = 1'b0; rnd_valid = 1'b0;
      req0_data = '0; req1_data = '0; rnd_data = '0; rst_n = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      do_reset();
      do_reset();

      // Arbitration table from reset; expected {req0_ready, req1_ready, rnd_ready}.
      tbl[0] = '{1'b0, 1'b0, 1'b1, 3'b000, 3'b000};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b000};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 3'b101, 3'b101};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 3'b011, 3'b101};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 3'b011, 3'b011};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 3'b101, 3'b101};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b000};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 3'b011, 3'b101};
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].v0, tbl[i].v1, tbl[i].rv, 1'b1, rdw(), rdw(), rrnd());
`ifdef SBOX_SCHED_RR_EN
         ev = tbl[i].e_rr;
`else
         ev = tbl[i].e_fp;
`endif
         chk("table_grant", 64'({o_r0, o_r1, o_rr}), 64'(ev));
      end
      for (int i = 0; i < 5; i++) idle();

      // Single op: response only at T+4, busy over T+1..T+4.
      do_reset();
      step(1'b1, 1'b0, 1'b1, 1'b1, rdw(), rdw(), rrnd());
      chk("single_ready", 64'(o_r0), 64'h1);
      for (int k = 1; k <= 5; k++) begin
         chk("single_resp_valid", 64'(resp_valid), 64'(k == 4));
         chk("single_busy", 64'(busy), 64'(k <= 4));
         if (k == 4) chk("single_resp_id", 64'(resp_id), 64'h0);
         idle();
      end

      // Randomness staging with a known bundle.
      begin
         logic [RW-1:0] rk;
         rk = rrnd();
         step(1'b0, 1'b1, 1'b1, 1'b1, rdw(), rdw(), rk);
         chk("stage1", 64'(sb_rnd1), 64'(rk[O1 +: S1W]));
         chk("stage1_others", 64'(sb_rnd2) | 64'(sb_rnd3), 64'h0);
         idle();
         for (int k = 0; k < 4; k++) idle();
      end

      // Contention: both requesters valid for 4 cycles after reset.
      do_reset();
`ifdef SBOX_SCHED_RR_EN
      gseq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      gseq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b1, rdw(), rdw(), rrnd());
         chk("contention_grant", 64'(o_r1), 64'(gseq[i]));
      end
      for (int i = 0; i < 4; i++) begin
         chk("contention_resp_id", 64'({resp_valid, resp_id}), 64'({1'b1, gseq[i]}));
         idle();
      end
      idle();

      // Randomness starvation.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b1, rdw(), rdw(), rrnd());
         chk("starve_no_ready", 64'({o_r0, o_r1, o_rr}), 64'h0);
      end
      step(1'b1, 1'b1, 1'b1, 1'b1, rdw(), rdw(), rrnd());
      chk("starve_first_grant", 64'({o_r0, o_r1}), 64'b10);
      for (int i = 0; i < 6; i++) idle();

      // Reset mid-flight: the in-flight ops must vanish.
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 1'b1, rdw(), rdw(), rrnd());
      step(1'b1, 1'b0, 1'b1, 1'b0, rdw(), rdw(), rrnd());
      for (int i = 0; i < 6; i++) begin
         chk("midreset_quiet", 64'({resp_valid, busy}), 64'h0);
         idle();
      end

      // Golden S-box values through the whole path.
      step(1'b1, 1'b0, 1'b1, 1'b1, mask_w(32'h00530053, rdw()), rdw(), rrnd());
      for (int i = 0; i < 3; i++) idle();
      exp_w = 64'h63ED63ED;
      chk("golden_sbox", 64'(unmask_w(resp_data)), exp_w);
      for (int i = 0; i < 3; i++) idle();

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 4) != 0,
              $urandom_range(0, 63) != 0, mask_w($urandom(), rdw()), mask_w($urandom(), rdw()), rrnd());
      end
      for (int i = 0; i < 6; i++) idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
